adder_with_valid_pair: RTL and testbench

Signed two-operand adder that pairs operands arriving on independent valid-qualified streams and emits one registered sum per matched pair. Each operand may arrive in the same cycle as its partner or in any earlier cycle; an unmatched operand is held until its partner arrives. The block sits in the DSP datapath wherever two independently timed sample streams are combined, such as offset or correction addition.

---
 rtl/adder_pkg.sv | 33 +++
 rtl/adder_with_valid_pair_if.sv | 23 ++
 rtl/adder_with_valid_pair_operand_hold.sv | 46 ++++
 rtl/adder_with_valid_pair.sv | 109 ++++++++++
 tb/tb_adder_with_valid_pair.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and arithmetic helpers for the valid-paired signed adder.
package adder_pkg;

  localparam int DATA_W = 32;
  localparam int MAX_W  = 64;

  // Largest two's complement value representable in w bits, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] signed_max(input int w);
    logic [MAX_W-1:0] v;
    v = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      v[i] = (i < (w - 1));
    end
    return v;
  endfunction

  // Smallest two's complement value representable in w bits, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] signed_min(input int w);
    logic [MAX_W-1:0] v;
    v = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      v[i] = (i == (w - 1));
    end
    return v;
  endfunction

  // Same-sign operands producing an opposite-sign result means the sum left the range.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                        input logic sign_sum);
    return (sign_a == sign_b) && (sign_sum != sign_a);
  endfunction

endpackage

// File: rtl/adder_with_valid_pair_if.sv
// Operand streams and result bundle for adder_with_valid_pair.
interface adder_with_valid_pair_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_data_a;
  logic             i_valid_a;
  logic [WIDTH-1:0] i_data_b;
  logic             i_valid_b;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_overflow;
  logic             o_overrun;

  modport master (
    output i_data_a, i_valid_a, i_data_b, i_valid_b,
    input  o_data, o_valid, o_overflow, o_overrun
  );

  modport slave (
    input  i_data_a, i_valid_a, i_data_b, i_valid_b,
    output o_data, o_valid, o_overflow, o_overrun
  );
endinterface

// File: rtl/adder_with_valid_pair_operand_hold.sv
// One side of the pairing logic: holds an unmatched operand until its partner shows up.
module adder_with_valid_pair_operand_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [WIDTH-1:0] data,
  input  logic             pair_done,
  output logic [WIDTH-1:0] eff_data,
  output logic             present,
  output logic             overrun
);

  logic [WIDTH-1:0] hold_r;
  logic             pending_r;

  // An incoming value always takes precedence over the held one.
  always_comb begin
    eff_data = hold_r;
    if (strobe) begin
      eff_data = data;
    end else begin
      eff_data = hold_r;
    end
  end

  assign present = strobe | pending_r;
  assign overrun = strobe & pending_r & ~pair_done;

  // Capture unmatched operands; a completed pair releases the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r    <= {WIDTH{1'b0}};
      pending_r <= 1'b0;
    end else if (pair_done) begin
      pending_r <= 1'b0;
    end else if (strobe) begin
      hold_r    <= data;
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

endmodule

// File: rtl/adder_with_valid_pair.sv
// Signed adder pairing two independent valid-qualified operand streams.
// Build option: ADDER_WITH_VALID_SATURATE_EN clamps overflowed sums instead of wrapping.
module adder_with_valid_pair
  import adder_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  adder_with_valid_pair_if.slave bus
);

  logic [WIDTH-1:0] eff_a_s;
  logic [WIDTH-1:0] eff_b_s;
  logic             present_a_s;
  logic             present_b_s;
  logic             overrun_a_s;
  logic             overrun_b_s;
  logic             complete_s;
  logic [WIDTH:0]   sum_wide_s;
  logic             overflow_s;
  logic [WIDTH-1:0] result_s;

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overflow_r;
  logic             overrun_r;

  assign complete_s = present_a_s & present_b_s;

  adder_with_valid_pair_operand_hold #(.WIDTH(WIDTH)) u_hold_a (
    .clk       (i_clk),
    .reset     (i_reset),
    .strobe    (bus.i_valid_a),
    .data      (bus.i_data_a),
    .pair_done (complete_s),
    .eff_data  (eff_a_s),
    .present   (present_a_s),
    .overrun   (overrun_a_s)
  );

  adder_with_valid_pair_operand_hold #(.WIDTH(WIDTH)) u_hold_b (
    .clk       (i_clk),
    .reset     (i_reset),
    .strobe    (bus.i_valid_b),
    .data      (bus.i_data_b),
    .pair_done (complete_s),
    .eff_data  (eff_b_s),
    .present   (present_b_s),
    .overrun   (overrun_b_s)
  );

  // Sign-extend by one bit so the top bit carries the true sign of the sum.
  assign sum_wide_s = {eff_a_s[WIDTH-1], eff_a_s} + {eff_b_s[WIDTH-1], eff_b_s};
  assign overflow_s = add_overflow(eff_a_s[WIDTH-1], eff_b_s[WIDTH-1], sum_wide_s[WIDTH-1]);

`ifdef ADDER_WITH_VALID_SATURATE_EN
  localparam logic [MAX_W-1:0] SMAX_FULL = signed_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN_FULL = signed_min(WIDTH);

  // Clamp toward the true sign of the unbounded sum.
  always_comb begin
    result_s = sum_wide_s[WIDTH-1:0];
    if (overflow_s) begin
      if (sum_wide_s[WIDTH]) begin
        result_s = SMIN_FULL[WIDTH-1:0];
      end else begin
        result_s = SMAX_FULL[WIDTH-1:0];
      end
    end else begin
      result_s = sum_wide_s[WIDTH-1:0];
    end
  end
`else
  logic unused_carry_s;
  assign unused_carry_s = sum_wide_s[WIDTH];

  // Plain two's complement wrap-around.
  always_comb begin
    result_s = sum_wide_s[WIDTH-1:0];
  end
`endif

  // Output registers; data and overflow only move when a pair completes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_r     <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      valid_r   <= complete_s;
      overrun_r <= overrun_a_s | overrun_b_s;
      if (complete_s) begin
        data_r     <= result_s;
        overflow_r <= overflow_s;
      end else begin
        data_r     <= data_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.o_data     = data_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_overflow = overflow_r;
  assign bus.o_overrun  = overrun_r;

endmodule

// File: tb/tb_adder_with_valid_pair.sv
// Directed bench for adder_with_valid_pair with hand-computed expected values.
module tb_adder_with_valid_pair;

  logic i_clk;
  logic i_reset;
  int   n_vec;
  int   n_err;

  adder_with_valid_pair_if #(.WIDTH(32)) bus ();

  adder_with_valid_pair dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, then drop the strobes.
  task automatic tick();
    @(posedge i_clk);
    #1;
    bus.i_valid_a = 1'b0;
    bus.i_valid_b = 1'b0;
  endtask

  task automatic drive(input logic va, input logic [31:0] a, input logic vb, input logic [31:0] b);
    bus.i_valid_a = va;
    bus.i_data_a  = a;
    bus.i_valid_b = vb;
    bus.i_data_b  = b;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    i_reset = 1'b0;
    chk("reset_data", bus.o_data, 32'd0);
    chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset_ovf", {31'd0, bus.o_overflow}, 32'd0);
    chk("reset_overrun", {31'd0, bus.o_overrun}, 32'd0);

    // Paired strobes, 16 cycles apart
    drive(1'b1, -32'sd99, 1'b1, 32'sd23);
    tick();
    chk("pair1_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("pair1_data", bus.o_data, -32'sd76);
    chk("pair1_ovf", {31'd0, bus.o_overflow}, 32'd0);
    tick();
    chk("pair1_pulse", {31'd0, bus.o_valid}, 32'd0);
    chk("pair1_hold", bus.o_data, -32'sd76);
    for (int i = 0; i < 14; i++) tick();
    drive(1'b1, -32'sd98, 1'b1, 32'sd23);
    tick();
    chk("pair2_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("pair2_data", bus.o_data, -32'sd75);
    chk("pair2_ovf", {31'd0, bus.o_overflow}, 32'd0);

    // A early, B three cycles later
    drive(1'b1, 32'd5, 1'b0, 32'd0);
    tick();
    chk("late_b_wait0", {31'd0, bus.o_valid}, 32'd0);
    tick();
    tick();
    chk("late_b_wait2", {31'd0, bus.o_valid}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'd7);
    tick();
    chk("late_b_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("late_b_data", bus.o_data, 32'd12);
    drive(1'b0, 32'd0, 1'b1, 32'd3);
    tick();
    chk("pend_clear", {31'd0, bus.o_valid}, 32'd0);
    drive(1'b1, 32'd0, 1'b0, 32'd0);
    tick();
    chk("b_held_data", bus.o_data, 32'd3);

    // Overrun: A replaced before B arrives
    drive(1'b1, 32'd5, 1'b0, 32'd0);
    tick();
    chk("ovr_first", {31'd0, bus.o_overrun}, 32'd0);
    drive(1'b1, 32'd9, 1'b0, 32'd0);
    tick();
    chk("ovr_pulse", {31'd0, bus.o_overrun}, 32'd1);
    chk("ovr_novalid", {31'd0, bus.o_valid}, 32'd0);
    tick();
    chk("ovr_once", {31'd0, bus.o_overrun}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'd1);
    tick();
    chk("ovr_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("ovr_data", bus.o_data, 32'd10);

    // Incoming value beats held value on the completing cycle
    drive(1'b1, 32'd50, 1'b0, 32'd0);
    tick();
    drive(1'b1, 32'd60, 1'b1, 32'd1);
    tick();
    chk("beat_data", bus.o_data, 32'd61);
    chk("beat_overrun", {31'd0, bus.o_overrun}, 32'd0);

    // Overflow both directions, then a clean sum clears the flag
    drive(1'b1, 32'h7FFF_FFFF, 1'b1, 32'd1);
    tick();
    chk("ovf_pos_flag", {31'd0, bus.o_overflow}, 32'd1);
`ifdef ADDER_WITH_VALID_SATURATE_EN
    chk("ovf_pos_data", bus.o_data, 32'h7FFF_FFFF);
`else
    chk("ovf_pos_data", bus.o_data, 32'h8000_0000);
`endif
    drive(1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("ovf_neg_flag", {31'd0, bus.o_overflow}, 32'd1);
`ifdef ADDER_WITH_VALID_SATURATE_EN
    chk("ovf_neg_data", bus.o_data, 32'h8000_0000);
`else
    chk("ovf_neg_data", bus.o_data, 32'h7FFF_FFFF);
`endif
    tick();
    chk("ovf_hold", {31'd0, bus.o_overflow}, 32'd1);
    drive(1'b1, 32'd1, 1'b1, 32'd1);
    tick();
    chk("ovf_clear", {31'd0, bus.o_overflow}, 32'd0);
    chk("ovf_clear_data", bus.o_data, 32'd2);

    // Reset discards a pending A
    drive(1'b1, 32'd6, 1'b0, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rst_data", bus.o_data, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'd4);
    tick();
    chk("rst_discard", {31'd0, bus.o_valid}, 32'd0);
    tick();
    chk("rst_discard2", {31'd0, bus.o_valid}, 32'd0);
    drive(1'b1, 32'd1, 1'b0, 32'd0);
    tick();
    chk("rst_b_pend", bus.o_data, 32'd5);

    // Reset on a completing cycle suppresses the result
    i_reset = 1'b1;
    drive(1'b1, 32'd40, 1'b1, 32'd2);
    tick();
    i_reset = 1'b0;
    chk("rst_cmp_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_cmp_data", bus.o_data, 32'd0);

    // Back-to-back pairs every cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd100 + 32'(i), 1'b1, -32'sd3);
      tick();
      chk("stream_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("stream_data", bus.o_data, 32'd97 + 32'(i));
    end
    tick();
    chk("stream_end", {31'd0, bus.o_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
